fetch_unit: RTL and testbench

Instruction-fetch stage of the 64-bit pipeline, directly upstream of the IF/ID pipeline register. It holds the program counter, drives the instruction-memory address, and predicts taken branches with a 2-bit-counter branch history table (BHT) and a direct-mapped branch target buffer (BTB). It produces the `pc` and `prediction` pair latched by IF/ID, and redirects fetch when EX reports a misprediction.

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage of the 64-bit pipeline. It holds the program
//   counter and drives the instruction-memory address. It predicts taken
//   branches with a table of 2-bit counters (BHT) and a direct-mapped branch
//   target buffer (BTB). When EX reports a misprediction it redirects fetch.
//
//   Build option: define FETCH_PREDICTOR_EN to build the BHT/BTB. When the
//   macro is undefined, no tables exist and fetch is purely sequential
//   (subject to redirect and stall).
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   pc_write          1 = advance PC, 0 = hold (stall)
//   ex_branch_valid   a conditional branch resolved in EX this cycle
//   ex_pc             PC of that branch (training index/tag)
//   ex_taken          actual direction
//   ex_target         actual taken target
//   ex_mispredict     EX detected a wrong prediction
//   ex_correct_pc     PC to fetch next on a mispredict
//   pc                current fetch PC / instruction-memory address
//   prediction        instruction at pc is predicted taken
//   pred_target       predicted next PC (pc+4 when not predicted taken)
//   flush             squash younger instructions in IF/ID (= ex_mispredict)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          BHT_ENTRIES = 64,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        ex_branch_valid,
  input  logic [63:0] ex_pc,
  input  logic        ex_taken,
  input  logic [63:0] ex_target,
  input  logic        ex_mispredict,
  input  logic [63:0] ex_correct_pc,
  output logic [63:0] pc,
  output logic        prediction,
  output logic [63:0] pred_target,
  output logic        flush
);

  localparam int BHT_W = $clog2(BHT_ENTRIES);
  localparam int BTB_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 64 - BTB_W - 2;

  logic [63:0] pc_q, pc_d;
  logic [63:0] pc_plus4_s;
  logic        unused_s;

  // Natural 64-bit wrap: ...FFFC + 4 = 0.
  assign pc_plus4_s = pc_q + 64'd4;

`ifdef FETCH_PREDICTOR_EN
  logic [BHT_ENTRIES-1:0][1:0] bht_q, bht_d;
  logic [BTB_ENTRIES-1:0]      btb_valid_q, btb_valid_d;
  // Tags and targets carry no reset; the valid bits qualify them.
  logic [TAG_W-1:0]            btb_tag_q    [BTB_ENTRIES];
  logic [63:0]                 btb_target_q [BTB_ENTRIES];

  logic [BHT_W-1:0] bidx_s, ex_bidx_s;
  logic [BTB_W-1:0] tidx_s, ex_tidx_s;
  logic [TAG_W-1:0] tag_s, ex_tag_s;
  logic             btb_hit_s;
  logic             btb_we_s;

  assign bidx_s    = pc_q[BHT_W+1:2];
  assign tidx_s    = pc_q[BTB_W+1:2];
  assign tag_s     = pc_q[63:BTB_W+2];
  assign ex_bidx_s = ex_pc[BHT_W+1:2];
  assign ex_tidx_s = ex_pc[BTB_W+1:2];
  assign ex_tag_s  = ex_pc[63:BTB_W+2];

  // Lookup reads pre-edge table contents, so a same-index training write
  // only becomes visible in the following cycle.
  assign btb_hit_s   = btb_valid_q[tidx_s] && (btb_tag_q[tidx_s] == tag_s);
  assign prediction  = btb_hit_s && bht_q[bidx_s][1];
  assign pred_target = prediction ? btb_target_q[tidx_s] : pc_plus4_s;
  assign btb_we_s    = ex_branch_valid && ex_taken;
  assign unused_s    = ^ex_pc[1:0];

  // Training: saturating counter update and BTB valid set on taken branches.
  always_comb begin
    bht_d       = bht_q;
    btb_valid_d = btb_valid_q;
    if (ex_branch_valid) begin
      if (ex_taken) begin
        if (bht_q[ex_bidx_s] != 2'b11) begin
          bht_d[ex_bidx_s] = bht_q[ex_bidx_s] + 2'b01;
        end else begin
          bht_d[ex_bidx_s] = 2'b11;
        end
        btb_valid_d[ex_tidx_s] = 1'b1;
      end else begin
        if (bht_q[ex_bidx_s] != 2'b00) begin
          bht_d[ex_bidx_s] = bht_q[ex_bidx_s] - 2'b01;
        end else begin
          bht_d[ex_bidx_s] = 2'b00;
        end
      end
    end else begin
      bht_d = bht_q;
    end
  end

  // Counter and valid-bit registers; reset to weakly-not-taken / invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bht_q       <= {BHT_ENTRIES{2'b01}};
      btb_valid_q <= {BTB_ENTRIES{1'b0}};
    end else begin
      bht_q       <= bht_d;
      btb_valid_q <= btb_valid_d;
    end
  end

  // BTB tag/target storage; a conflicting entry is simply overwritten.
  always_ff @(posedge clk) begin
    if (btb_we_s) begin
      btb_tag_q[ex_tidx_s]    <= ex_tag_s;
      btb_target_q[ex_tidx_s] <= ex_target;
    end
  end
`else
  assign prediction  = 1'b0;
  assign pred_target = pc_plus4_s;
  assign unused_s    = ^{ex_branch_valid, ex_pc, ex_taken, ex_target};
`endif

  // Next-PC select: redirect beats stall, stall beats prediction, else +4.
  always_comb begin
    pc_d = pc_q;
    if (ex_mispredict) begin
      pc_d = ex_correct_pc;
    end else if (!pc_write) begin
      pc_d = pc_q;
    end else begin
      pc_d = pred_target;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc    = pc_q;
  assign flush = ex_mispredict;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed steps followed by randomized traffic, checked against a
//   behavioural model of the fetch/predict rules kept in this file.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h1000;
`ifdef FETCH_PREDICTOR_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        ex_branch_valid;
  logic [63:0] ex_pc;
  logic        ex_taken;
  logic [63:0] ex_target;
  logic        ex_mispredict;
  logic [63:0] ex_correct_pc;
  logic [63:0] pc;
  logic        prediction;
  logic [63:0] pred_target;
  logic        flush;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] m_pc;
  int          m_cnt   [64];
  bit          m_valid [16];
  logic [63:0] m_bpc   [16];   // full PC of the branch that owns the entry
  logic [63:0] m_tgt   [16];

  fetch_unit #(.RESET_PC(RST_PC), .BHT_ENTRIES(64), .BTB_ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write),
    .ex_branch_valid(ex_branch_valid), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_mispredict(ex_mispredict),
    .ex_correct_pc(ex_correct_pc), .pc(pc), .prediction(prediction),
    .pred_target(pred_target), .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic int bi(logic [63:0] a);
    return int'((a >> 2) % 64);
  endfunction

  function automatic int ti(logic [63:0] a);
    return int'((a >> 2) % 16);
  endfunction

  function automatic bit m_pred(logic [63:0] a);
    return PRED_EN && m_valid[ti(a)] && ((m_bpc[ti(a)] >> 6) == (a >> 6))
           && (m_cnt[bi(a)] >= 2);
  endfunction

  function automatic logic [63:0] m_ptgt(logic [63:0] a);
    return m_pred(a) ? m_tgt[ti(a)] : a + 64'd4;
  endfunction

  task automatic m_reset();
    m_pc = RST_PC;
    for (int i = 0; i < 64; i++) m_cnt[i] = 1;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk64(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check pc.
  task automatic cyc(bit pw, bit bv, logic [63:0] bpc, bit tk,
                     logic [63:0] tgt, bit mp, logic [63:0] cpc);
    logic [63:0] nxt;
    pc_write = pw; ex_branch_valid = bv; ex_pc = bpc; ex_taken = tk;
    ex_target = tgt; ex_mispredict = mp; ex_correct_pc = cpc;
    #1;
    chk1 ("prediction",  prediction,  m_pred(m_pc));
    chk64("pred_target", pred_target, m_ptgt(m_pc));
    chk1 ("flush",       flush,       mp);
    nxt = mp ? cpc : (pw ? m_ptgt(m_pc) : m_pc);
    if (PRED_EN && bv) begin
      if (tk) begin
        m_cnt[bi(bpc)] = (m_cnt[bi(bpc)] + 1 > 3) ? 3 : m_cnt[bi(bpc)] + 1;
        m_valid[ti(bpc)] = 1'b1;
        m_bpc[ti(bpc)]   = bpc;
        m_tgt[ti(bpc)]   = tgt;
      end else begin
        m_cnt[bi(bpc)] = (m_cnt[bi(bpc)] - 1 < 0) ? 0 : m_cnt[bi(bpc)] - 1;
      end
    end
    m_pc = nxt;
    @(posedge clk);
    #1;
    chk64("pc", pc, m_pc);
  endtask

  task automatic adv(int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic redirect(logic [63:0] a, bit pw);
    cyc(pw, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, a);
  endtask

  initial begin
    rst_n = 1'b0; pc_write = 1'b0; ex_branch_valid = 1'b0; ex_pc = 64'h0;
    ex_taken = 1'b0; ex_target = 64'h0; ex_mispredict = 1'b0; ex_correct_pc = 64'h0;
    m_reset();
    #12;
    // Reset state
    chk64("rst_pc",     pc,          RST_PC);
    chk1 ("rst_pred",   prediction,  1'b0);
    chk64("rst_ptgt",   pred_target, RST_PC + 64'd4);
    chk1 ("rst_flush",  flush,       1'b0);
    rst_n = 1'b1;

    // Sequential fetch, stall hold at 0x1008, resume
    adv(2);
    chk64("seq_1008", pc, 64'h1008);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    chk64("stall_hold", pc, 64'h1008);
    adv(2);
    chk64("resume_1010", pc, 64'h1010);

    // Train 0x2000 taken -> 0x3000 twice, then fetch it
    cyc(1'b1, 1'b1, 64'h2000, 1'b1, 64'h3000, 1'b0, 64'h0);
    cyc(1'b1, 1'b1, 64'h2000, 1'b1, 64'h3000, 1'b0, 64'h0);
    redirect(64'h2000, 1'b1);
    cyc(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);   // predicted -> 0x3000

    // Two not-taken reports while stalled on 0x2000
    redirect(64'h2000, 1'b1);
    cyc(1'b0, 1'b1, 64'h2000, 1'b0, 64'h0, 1'b0, 64'h0);
    cyc(1'b0, 1'b1, 64'h2000, 1'b0, 64'h0, 1'b0, 64'h0);
    adv(1);                                              // now not predicted

    // Retrain, then alias check at 0x2040 (same BTB index, other tag)
    cyc(1'b1, 1'b1, 64'h2000, 1'b1, 64'h3000, 1'b0, 64'h0);
    cyc(1'b1, 1'b1, 64'h2000, 1'b1, 64'h3000, 1'b0, 64'h0);
    redirect(64'h2040, 1'b1);
    adv(1);
    chk64("alias_seq", pc, 64'h2044);

    // Mispredict overrides stall
    redirect(64'h4000, 1'b0);
    chk64("mp_beats_stall", pc, 64'h4000);

    // Wrap-around
    redirect(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    adv(1);
    chk64("wrap", pc, 64'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 9) < 8),
          ($urandom_range(0, 2) == 0),
          64'($urandom_range(0, 511)) << 2,
          $urandom_range(0, 1) == 1,
          64'($urandom_range(0, 511)) << 2,
          ($urandom_range(0, 9) == 0),
          64'($urandom_range(0, 511)) << 2);
    end

    // Async reset mid-cycle with training and redirect pending
    redirect(64'h2000, 1'b1);
    cyc(1'b1, 1'b1, 64'h2000, 1'b1, 64'h3000, 1'b0, 64'h0);
    cyc(1'b1, 1'b1, 64'h2000, 1'b1, 64'h3000, 1'b0, 64'h0);
    pc_write = 1'b1; ex_branch_valid = 1'b1; ex_pc = 64'h2000; ex_taken = 1'b1;
    ex_target = 64'h3000; ex_mispredict = 1'b1; ex_correct_pc = 64'h5000;
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk64("async_rst_pc", pc, RST_PC);
    @(posedge clk);
    #2;
    chk64("rst_held_pc", pc, RST_PC);
    rst_n = 1'b1;
    redirect(64'h2000, 1'b1);
    chk1("post_rst_pred", prediction, 1'b0);
    adv(1);
    chk64("post_rst_seq", pc, 64'h2004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
